// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, defaults and counter sizing for the IF/MEM bus arbiter
package mem_arbiter_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbBusyIf  = 2'd1,
    ArbBusyMem = 2'd2
  } arb_state_e;
  function automatic int cnt_w(input int t);
    return t > 1 ? $clog2(t) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: single-port multi-cycle memory bus between the arbiter (master) and memory (slave)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        sel;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch and data access, MEM wins ties
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ready_o,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o,
  mem_arbiter_if.master     bus,
  output logic              err_o
);
  localparam int CW = cnt_w(TIMEOUT);
  arb_state_e    state;
  logic [CW-1:0] cnt;
  logic          if_elig;
  logic          mem_elig;
  logic          to;
  logic          done;
  // A requester being retired this cycle must not be re-granted on its own stale request
  always_comb begin
    if_elig        = if_req_i & ~if_ready_o;
    mem_elig       = mem_req_i & ~mem_ready_o;
    stallreq_if_o  = if_req_i & ~if_ready_o;
    stallreq_mem_o = mem_req_i & ~mem_ready_o;
    to             = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    done           = bus.ack | to;
  end
  // Arbitration FSM with registered bus fields, ready pulses, read data and sticky timeout error
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= ArbIdle;
      cnt         <= '0;
      bus.req     <= 1'b0;
      bus.we      <= 1'b0;
      bus.addr    <= '0;
      bus.sel     <= '0;
      bus.wdata   <= '0;
      if_rdata_o  <= '0;
      if_ready_o  <= 1'b0;
      mem_rdata_o <= '0;
      mem_ready_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
      case (state)
        ArbIdle:
          if (mem_elig) begin
            state     <= ArbBusyMem;
            cnt       <= '0;
            bus.req   <= 1'b1;
            bus.we    <= mem_we_i;
            bus.addr  <= mem_addr_i;
            bus.sel   <= mem_sel_i;
            bus.wdata <= mem_wdata_i;
          end else if (if_elig) begin
            state     <= ArbBusyIf;
            cnt       <= '0;
            bus.req   <= 1'b1;
            bus.we    <= 1'b0;
            bus.addr  <= if_addr_i;
            bus.sel   <= 4'hf;
            bus.wdata <= '0;
          end
        ArbBusyIf:
          if (done) begin
            state   <= ArbIdle;
            bus.req <= 1'b0;
            err_o   <= err_o | ~bus.ack;
            if (if_req_i) begin
              if_ready_o <= 1'b1;
              if_rdata_o <= bus.ack ? bus.rdata : '0;
            end
          end else cnt <= cnt + 1'b1;
        ArbBusyMem:
          if (done) begin
            state   <= ArbIdle;
            bus.req <= 1'b0;
            err_o   <= err_o | ~bus.ack;
            if (mem_req_i) begin
              mem_ready_o <= 1'b1;
              if (!bus.ack) mem_rdata_o <= '0;
              else if (!bus.we) mem_rdata_o <= bus.rdata;
            end
          end else cnt <= cnt + 1'b1;
        default: state <= ArbIdle;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for the IF/MEM memory bus arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        err;
  int          errs = 0;
  int          checks = 0;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_sel_i(mem_sel),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
    .stallreq_if_o(stall_if), .stallreq_mem_o(stall_mem), .bus(bus.master), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b0; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_sel = 0; mem_wdata = 0;
    bus.ack = 0; bus.rdata = 0;
    step(); step();
    checks++; if (bus.req !== 1'b0) begin errs++; $display("FAIL reset_bus_req: got %b want 0", bus.req); end
    checks++; if ({bus.addr, bus.wdata, bus.sel, bus.we} !== 69'd0) begin errs++; $display("FAIL reset_bus_fields: got %h want 0", {bus.addr, bus.wdata, bus.sel, bus.we}); end
    checks++; if ({if_ready, mem_ready, err, stall_if, stall_mem} !== 5'b0) begin errs++; $display("FAIL reset_flags: got %b want 00000", {if_ready, mem_ready, err, stall_if, stall_mem}); end
    checks++; if ({if_rdata, mem_rdata} !== 64'd0) begin errs++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, mem_rdata}); end
    rst = 1'b1;
    step();
  endtask
  task automatic test_fetch();
    if_req = 1; if_addr = 32'h100;
    #1 checks++; if (stall_if !== 1'b1) begin errs++; $display("FAIL fetch_stall_req: got %b want 1", stall_if); end
    step();
    checks++; if ({bus.req, bus.we, bus.addr} !== {2'b10, 32'h100}) begin errs++; $display("FAIL fetch_bus: got req=%b we=%b addr=%h want 1 0 100", bus.req, bus.we, bus.addr); end
    step();
    bus.ack = 1; bus.rdata = 32'h13;
    step();
    bus.ack = 0;
    checks++; if ({if_ready, if_rdata} !== {1'b1, 32'h13}) begin errs++; $display("FAIL fetch_ready: got rdy=%b data=%h want 1 00000013", if_ready, if_rdata); end
    checks++; if ({bus.req, stall_if} !== 2'b00) begin errs++; $display("FAIL fetch_done: got req=%b stall=%b want 0 0", bus.req, stall_if); end
    if_req = 0;
    step();
    checks++; if (if_ready !== 1'b0) begin errs++; $display("FAIL fetch_pulse: got %b want 0", if_ready); end
  endtask
  task automatic test_priority();
    mem_req = 1; mem_we = 0; mem_addr = 32'h2000; mem_sel = 4'hf; if_req = 1; if_addr = 32'h104;
    step();
    checks++; if ({bus.req, bus.we, bus.addr} !== {2'b10, 32'h2000}) begin errs++; $display("FAIL prio_mem_first: got req=%b we=%b addr=%h want 1 0 2000", bus.req, bus.we, bus.addr); end
    checks++; if ({stall_if, stall_mem} !== 2'b11) begin errs++; $display("FAIL prio_stalls: got %b want 11", {stall_if, stall_mem}); end
    bus.ack = 1; bus.rdata = 32'hCAFE0001;
    step();
    bus.ack = 0;
    checks++; if ({mem_ready, mem_rdata, stall_if} !== {1'b1, 32'hCAFE0001, 1'b1}) begin errs++; $display("FAIL prio_mem_done: got rdy=%b data=%h stall_if=%b want 1 cafe0001 1", mem_ready, mem_rdata, stall_if); end
    mem_req = 0;
    step();
    checks++; if ({bus.req, bus.addr, if_ready, stall_if} !== {1'b1, 32'h104, 2'b01}) begin errs++; $display("FAIL prio_if_grant: got req=%b addr=%h rdy=%b stall=%b want 1 104 0 1", bus.req, bus.addr, if_ready, stall_if); end
    bus.ack = 1; bus.rdata = 32'h93;
    step();
    bus.ack = 0;
    checks++; if ({if_ready, if_rdata, stall_if} !== {1'b1, 32'h93, 1'b0}) begin errs++; $display("FAIL prio_if_done: got rdy=%b data=%h stall=%b want 1 00000093 0", if_ready, if_rdata, stall_if); end
    if_req = 0;
    step();
  endtask
  task automatic test_store();
    mem_req = 1; mem_we = 1; mem_addr = 32'h40; mem_sel = 4'b0011; mem_wdata = 32'hDEADBEEF;
    step();
    checks++; if ({bus.req, bus.we, bus.sel, bus.addr, bus.wdata} !== {2'b11, 4'b0011, 32'h40, 32'hDEADBEEF}) begin errs++; $display("FAIL store_bus: got req=%b we=%b sel=%b addr=%h wdata=%h", bus.req, bus.we, bus.sel, bus.addr, bus.wdata); end
    bus.ack = 1; bus.rdata = 32'h55555555;
    step();
    bus.ack = 0;
    checks++; if ({mem_ready, mem_rdata} !== {1'b1, 32'hCAFE0001}) begin errs++; $display("FAIL store_done: got rdy=%b data=%h want 1 cafe0001", mem_ready, mem_rdata); end
    mem_req = 0; mem_we = 0;
    step();
  endtask
  task automatic test_flush();
    if_req = 1; if_addr = 32'h200;
    step();
    checks++; if ({bus.req, bus.addr} !== {1'b1, 32'h200}) begin errs++; $display("FAIL flush_grant: got req=%b addr=%h want 1 200", bus.req, bus.addr); end
    if_req = 0; if_addr = 32'h300;
    #1 checks++; if (stall_if !== 1'b0) begin errs++; $display("FAIL flush_stall: got %b want 0", stall_if); end
    step();
    bus.ack = 1; bus.rdata = 32'hBAD0BAD0;
    step();
    bus.ack = 0;
    checks++; if ({if_ready, if_rdata, bus.req} !== {1'b0, 32'h93, 1'b0}) begin errs++; $display("FAIL flush_discard: got rdy=%b data=%h req=%b want 0 00000093 0", if_ready, if_rdata, bus.req); end
    if_req = 1;
    step();
    checks++; if ({bus.req, bus.addr} !== {1'b1, 32'h300}) begin errs++; $display("FAIL flush_fresh: got req=%b addr=%h want 1 300", bus.req, bus.addr); end
    if_addr = 32'h304;
    step();
    checks++; if (bus.addr !== 32'h300) begin errs++; $display("FAIL flush_addr_hold: got %h want 300", bus.addr); end
    bus.ack = 1; bus.rdata = 32'h33;
    step();
    bus.ack = 0;
    checks++; if ({if_ready, if_rdata} !== {1'b1, 32'h33}) begin errs++; $display("FAIL flush_refetch: got rdy=%b data=%h want 1 00000033", if_ready, if_rdata); end
    if_req = 0;
    step();
  endtask
  task automatic test_timeout();
    mem_req = 1; mem_we = 0; mem_addr = 32'h80; mem_sel = 4'hf;
    step();
    for (int i = 1; i <= 8; i++) begin
      checks++; if ({bus.req, err} !== 2'b10) begin errs++; $display("FAIL timeout_busy%0d: got req=%b err=%b want 1 0", i, bus.req, err); end
      step();
    end
    checks++; if ({bus.req, err, mem_ready, mem_rdata} !== {3'b011, 32'h0}) begin errs++; $display("FAIL timeout_abort: got req=%b err=%b rdy=%b data=%h want 0 1 1 0", bus.req, err, mem_ready, mem_rdata); end
    mem_req = 0;
    step();
    checks++; if ({err, mem_ready} !== 2'b10) begin errs++; $display("FAIL timeout_sticky: got err=%b rdy=%b want 1 0", err, mem_ready); end
    bus.ack = 1; bus.rdata = 32'hFFFFFFFF;
    step();
    bus.ack = 0;
    checks++; if ({bus.req, if_ready, mem_ready, mem_rdata} !== {3'b000, 32'h0}) begin errs++; $display("FAIL idle_ack: got req=%b if_rdy=%b mem_rdy=%b data=%h want 0 0 0 0", bus.req, if_ready, mem_ready, mem_rdata); end
  endtask
  task automatic test_reset_busy();
    if_req = 1; if_addr = 32'h400;
    step();
    checks++; if (bus.req !== 1'b1) begin errs++; $display("FAIL rbusy_grant: got %b want 1", bus.req); end
    #2 rst = 1'b0;
    #1 checks++; if ({bus.req, err, if_ready, bus.addr, if_rdata} !== {3'b000, 64'h0}) begin errs++; $display("FAIL rbusy_clear: got req=%b err=%b rdy=%b addr=%h data=%h want all 0", bus.req, err, if_ready, bus.addr, if_rdata); end
    step();
    rst = 1'b1;
    step();
    checks++; if ({bus.req, bus.addr} !== {1'b1, 32'h400}) begin errs++; $display("FAIL rbusy_regrant: got req=%b addr=%h want 1 400", bus.req, bus.addr); end
    bus.ack = 1; bus.rdata = 32'h77;
    step();
    bus.ack = 0;
    checks++; if ({if_ready, if_rdata} !== {1'b1, 32'h77}) begin errs++; $display("FAIL rbusy_done: got rdy=%b data=%h want 1 00000077", if_ready, if_rdata); end
    if_req = 0;
    step();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_flush();
    test_timeout();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
